mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester and the data (load/store) requester of the memory stage. It issues one request per accepted handshake and records the owner of each outstanding request in an in-order tag FIFO. It routes every memory response back to the requester that issued it. It sits between the fetch/memory stages and the memory bus, and its back-pressure is what the pipeline stall logic ultimately waits on.

## Interface
- `MAX_OUTSTANDING`, 2: depth of the owner FIFO (power of two, ≥1); maximum requests in flight.
- `DATA_BURST`, 4: maximum consecutive data grants while a fetch is pending (fairness only).
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `i_valid`, `i_ready`  in/out  1  fetch request handshake.
- `i_addr`  in  32  fetch address (always a read).
- `i_rvalid`  out  1  fetch response valid.
- `i_rdata`  out  32  fetch response data.
- `d_valid`, `d_ready`  in/out  1  data request handshake.
- `d_addr`  in  32  data address.
- `d_we`  in  1  write enable.
- `d_wstrb`  in  4  byte strobes.
- `d_wdata`  in  32  write data.
- `d_rvalid`  out  1  data response valid (also the write acknowledge).
- `d_rdata`  out  32  data response data.
- `m_valid`, `m_ready`  out/in  1  memory request handshake.
- `m_addr`, `m_wdata`  out  32  memory request address and write data.
- `m_we`  out  1  memory write enable.
- `m_wstrb`  out  4  memory byte strobes.
- `m_rvalid`  in  1  memory response valid (one per request, in order, no back-pressure).
- `m_rdata`  in  32  memory response data.
- `busy`  out  1  owner FIFO not empty.

## Operation
- FSM states: IDLE, HOLD_I, HOLD_D. Reset state is IDLE.
- IDLE: selection is data if `d_valid`, else fetch if `i_valid`, subject to fairness. `m_*` is driven combinationally from the selected requester. `m_valid` = selected valid & !fifo_full.
- Accept: accept = `m_valid & m_ready`. The selected requester's ready = `m_ready & !fifo_full`; the other requester's ready = 0. On accept, the owner tag (0 = fetch, 1 = data) is pushed into the FIFO.
- Stall into HOLD: in IDLE, if `m_valid & !m_ready`, go to HOLD_I or HOLD_D.
- HOLD_x: selection is locked to x. Requester x must keep its request stable. Go to IDLE on accept.
- Fetch writes: `m_we` = 0 and `m_wstrb` = 0 for fetch.
- Responses: each `m_rvalid` pops the FIFO head. `i_rvalid` or `d_rvalid` = `m_rvalid` & head tag. Both `i_rdata` and `d_rdata` = `m_rdata`.
- Full FIFO: when the FIFO is full, no grants are issued and the FSM stays in IDLE. A pop and a push in the same cycle are both legal when the FIFO is full: the pop frees the slot, so `m_valid` may assert and the count is unchanged.
- Empty FIFO: `m_rvalid` while the FIFO is empty is a protocol error. It is ignored: no rvalid is routed and the count stays 0.
- Pointers: wrap modulo `MAX_OUTSTANDING`. The count is `$clog2(MAX_OUTSTANDING)+1` bits.
- Reset mid-transaction: the FIFO is flushed, the FSM returns to IDLE, and any memory responses still in flight are the bus's responsibility (they are ignored as in the empty case).

## Timing
- Request path is zero latency: a request is presented on `m_*` in the same cycle it is selected in IDLE.
- Response path is zero latency: `m_rvalid` to `i_rvalid`/`d_rvalid` in the same cycle.
- Throughput: one request per cycle while `m_ready`=1 and the FIFO is not full.
- Outputs during reset: `i_ready`, `d_ready`, `m_valid`, `i_rvalid`, `d_rvalid`, `busy` = 0. Data outputs are don't-care, driven 0.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined: a burst counter (width `$clog2(DATA_BURST)+1`) counts consecutive data accepts made while `i_valid`=1.
  - When the counter reaches `DATA_BURST`, the next IDLE selection is fetch, if `i_valid` is high.
  - The counter clears on any fetch accept, and on a data accept made while `i_valid`=0.
  - The counter resets to 0.
- Macro undefined: strict data priority, no counter. Fetch can starve.

## Test plan
- Idle reads: fetch `i_addr`=0x100 with `m_ready`=1, response 0xDEADBEEF two cycles later -> `i_rvalid`=1 with `i_rdata`=0xDEADBEEF, `d_rvalid`=0, `busy` falls afterwards.
- Contention: `i_valid` and `d_valid` both high in the same cycle -> data is granted first (`m_we` follows `d_we`), fetch is granted the next cycle, and responses are routed in order d then i.
- Hold: data store to 0x200 with `m_ready`=0 for 3 cycles while fetch is pending -> `m_addr` stays 0x200, the FSM stays in HOLD_D, and fetch is granted only after accept.
- Full: `MAX_OUTSTANDING`=2, two accepts with no responses -> `m_valid`=0 and both readies are 0. A response together with a third request in the same cycle -> the third request is accepted and the count stays 2.
- Fairness (macro defined, `DATA_BURST`=4): continuous `d_valid` and `i_valid` -> grant pattern D,D,D,D,I repeating. With the macro undefined -> data only.
- Async reset with 2 requests outstanding -> all outputs 0 immediately, `busy`=0, and late `m_rvalid` pulses produce no routed rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single memory port with an in-order owner-tag FIFO.
// Optional fetch fairness: define MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_BURST      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

  if (MAX_OUTSTANDING < 1 || DATA_BURST < 1) begin : g_param_check
    $fatal(1, "mem_arbiter: MAX_OUTSTANDING and DATA_BURST must be >= 1");
  end

  logic [1:0]                 state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              count_q;

  logic pop, full, force_i, sel_data, sel_valid, accept, head;

  // A same-cycle response frees a slot, so a full FIFO only blocks without a pop.
  assign pop  = m_rvalid & (count_q != '0);
  assign full = (count_q == CNT_FULL) & ~pop;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned BW = $clog2(DATA_BURST) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST);
  logic [BW-1:0] burst_q;

  assign force_i = (burst_q >= BURST_MAX) & i_valid;

  // Counts consecutive data grants taken while fetch was waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_q <= '0;
    end else if (accept) begin
      if (!sel_data || !i_valid) begin
        burst_q <= '0;
      end else if (burst_q < BURST_MAX) begin
        burst_q <= burst_q + 1'b1;
      end
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    sel_data = d_valid & ~force_i;
    case (state_q)
      HOLD_I:  sel_data = 1'b0;
      HOLD_D:  sel_data = 1'b1;
      default: sel_data = d_valid & ~force_i;
    endcase
  end

  assign sel_valid = sel_data ? d_valid : i_valid;
  assign m_valid   = resetn & sel_valid & ~full;
  assign accept    = m_valid & m_ready;
  assign i_ready   = resetn & ~sel_data & m_ready & ~full;
  assign d_ready   = resetn & sel_data & m_ready & ~full;

  assign m_addr  = !resetn ? '0 : (sel_data ? d_addr : i_addr);
  assign m_we    = resetn & sel_data & d_we;
  assign m_wstrb = (resetn && sel_data) ? d_wstrb : 4'b0;
  assign m_wdata = (resetn && sel_data) ? d_wdata : '0;

  assign head     = tag_q[rptr_q];
  assign i_rvalid = pop & ~head;
  assign d_rvalid = pop & head;
  assign i_rdata  = resetn ? m_rdata : '0;
  assign d_rdata  = resetn ? m_rdata : '0;
  assign busy     = (count_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m_valid && !m_ready) state_d = sel_data ? HOLD_D : HOLD_I;
      end
      HOLD_I, HOLD_D: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q[wptr_q] <= sel_data;
        wptr_q        <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
